// File: rtl/conv2d_stream_engine.sv
// Streaming 3x3 convolution over a raster-order frame using two line buffers.
// Optional macro CONV_RELU_EN clamps negative results to zero.
module conv2d_stream_engine #(
    parameter  int IMG_W  = 32,
    parameter  int IMG_H  = 32,
    parameter  int PIX_W  = 8,
    parameter  int COEF_W = 8,
    localparam int ACC_W  = PIX_W + COEF_W + 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     cfg_wr_en,
    input  logic [3:0]               cfg_addr,
    input  logic [COEF_W-1:0]        cfg_data,
    input  logic [PIX_W-1:0]         pixel_in,
    input  logic                     pixel_valid,
    output logic signed [ACC_W-1:0]  result_out,
    output logic                     result_valid,
    output logic                     busy,
    output logic                     done
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int K_DEF [9] = '{1, 0, -1, 2, 0, -2, 1, 0, -1};

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t                   state, state_nxt;
    logic [1:0]               flush_cnt;
    logic [XW-1:0]            x;
    logic [YW-1:0]            y;
    logic                     accept, last_pix, qual;
    logic signed [COEF_W-1:0] k [0:8];
    logic [PIX_W-1:0]         lb0 [0:IMG_W-1];
    logic [PIX_W-1:0]         lb1 [0:IMG_W-1];
    logic [PIX_W-1:0]         win [0:2][0:2];
    logic                     v0, v1, v2;
    logic signed [ACC_W-1:0]  prod_c [0:8];
    logic signed [ACC_W-1:0]  prod   [0:8];
    logic signed [ACC_W-1:0]  rsum   [0:2];
    logic signed [ACC_W-1:0]  sum_c;

    assign accept   = (state == RUN) && pixel_valid;
    assign last_pix = accept && (x == XW'(IMG_W - 1)) && (y == YW'(IMG_H - 1));
    assign qual     = accept && (x >= XW'(2)) && (y >= YW'(2));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (last_pix) state_nxt = FLUSH;
            end
            FLUSH: begin
                busy = 1'b1;
                if (flush_cnt == 2'd3) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || state != FLUSH) flush_cnt <= '0;
        else                       flush_cnt <= flush_cnt + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            x <= '0;
            y <= '0;
        end else if (accept) begin
            if (x == XW'(IMG_W - 1)) begin
                x <= '0;
                y <= (y == YW'(IMG_H - 1)) ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 9; i++) k[i] <= COEF_W'(K_DEF[i]);
        end else if (state == IDLE && cfg_wr_en && cfg_addr < 4'd9) begin
            k[cfg_addr] <= cfg_data;
        end
    end

    // lb0 holds row y-1 and lb1 row y-2; the window's right column is fed
    // from them at the current x before they are overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < IMG_W; i++) begin
                lb0[i] <= '0;
                lb1[i] <= '0;
            end
            for (int unsigned r = 0; r < 3; r++)
                for (int unsigned c = 0; c < 3; c++) win[r][c] <= '0;
            v0 <= 1'b0;
        end else begin
            v0 <= qual;
            if (accept) begin
                lb1[x] <= lb0[x];
                lb0[x] <= pixel_in;
                for (int unsigned r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= lb1[x];
                win[1][2] <= lb0[x];
                win[2][2] <= pixel_in;
            end
        end
    end

    always_comb begin
        for (int unsigned r = 0; r < 3; r++)
            for (int unsigned c = 0; c < 3; c++)
                prod_c[r*3+c] = ACC_W'(signed'({1'b0, win[r][c]})) * ACC_W'(k[r*3+c]);
    end

    assign sum_c = rsum[0] + rsum[1] + rsum[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 9; i++) prod[i] <= '0;
            for (int unsigned r = 0; r < 3; r++) rsum[r] <= '0;
            v1           <= 1'b0;
            v2           <= 1'b0;
            result_out   <= '0;
            result_valid <= 1'b0;
        end else begin
            prod <= prod_c;
            v1   <= v0;
            for (int unsigned r = 0; r < 3; r++)
                rsum[r] <= prod[r*3] + prod[r*3+1] + prod[r*3+2];
            v2           <= v1;
            result_valid <= v2;
            if (v2) begin
`ifdef CONV_RELU_EN
                result_out <= sum_c[ACC_W-1] ? '0 : sum_c;
`else
                result_out <= sum_c;
`endif
            end
        end
    end

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Randomized bench for conv2d_stream_engine against a direct-convolution model.
// Honours CONV_RELU_EN in the model when the design is built with it.
module tb_conv2d_stream_engine;

    localparam int IMG_W  = 32;
    localparam int IMG_H  = 32;
    localparam int PIX_W  = 8;
    localparam int COEF_W = 8;
    localparam int ACC_W  = PIX_W + COEF_W + 6;
    localparam int NRES   = (IMG_W - 2) * (IMG_H - 2);
    localparam int K_DEF [9] = '{1, 0, -1, 2, 0, -2, 1, 0, -1};

    logic                    clk = 1'b0;
    logic                    rst, start, cfg_wr_en, pixel_valid;
    logic [3:0]              cfg_addr;
    logic [COEF_W-1:0]       cfg_data;
    logic [PIX_W-1:0]        pixel_in;
    logic signed [ACC_W-1:0] result_out;
    logic                    result_valid, busy, done;

    conv2d_stream_engine #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .COEF_W(COEF_W)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
        .result_out(result_out), .result_valid(result_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct { longint val; int cyc; } exp_t;

    exp_t   expq[$];
    int     cyc = 0;
    int     vectors = 0;
    int     miscompares = 0;
    int     res_count = 0;
    longint last_res = 0;
    int     kmod [9];
    int     img [IMG_H][IMG_W];

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Every result is matched in order, with value and arrival cycle, against the model queue.
    always @(negedge clk) begin
        exp_t e;
        if (result_valid === 1'b1) begin
            if (expq.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                e = expq.pop_front();
                check("result", result_out, e.val);
                check("latency", cyc, e.cyc);
                last_res = e.val;
                res_count++;
            end
        end else begin
            check("hold", result_out, last_res);
            if (expq.size() > 0 && expq[0].cyc <= cyc) begin
                e = expq.pop_front();
                check("missing_valid", result_valid, 1);
            end
        end
    end

    function automatic longint model(input int px, input int py);
        longint s = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                s += longint'(img[py-2+r][px-2+c]) * longint'(kmod[r*3+c]);
`ifdef CONV_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int addr, input int data);
        cfg_wr_en = 1'b1;
        cfg_addr  = 4'(addr);
        cfg_data  = COEF_W'(data);
        tick();
        cfg_wr_en = 1'b0;
        if (addr < 9) kmod[addr] = data;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        expq.delete();
        last_res = 0;
        for (int i = 0; i < 9; i++) kmod[i] = K_DEF[i];
        tick();
        rst = 1'b0;
    endtask

    // pat: 0 constant cval, 1 ramp x, 2 random. gap: 0 none, 1 alternate, 2 random.
    task automatic run_frame(input int pat, input int cval, input int gap,
                             input bit rst_mid, input bit run_wr, input bit wr_with_start);
        int lastp_cyc = 0;
        int p;
        bit got;
        res_count = 0;
        start = 1'b1;
        if (wr_with_start) begin
            cfg_wr_en = 1'b1;
            cfg_addr  = 4'd4;
            cfg_data  = COEF_W'(3);
        end
        tick();
        start     = 1'b0;
        cfg_wr_en = 1'b0;
        if (wr_with_start) kmod[4] = 3;
        check("busy_run", busy, 1);
        for (int y = 0; y < IMG_H; y++) begin
            for (int x = 0; x < IMG_W; x++) begin
                if (rst_mid && x == 10 && y == 10) begin
                    do_reset();
                    check("busy_after_rst", busy, 0);
                    check("valid_after_rst", result_valid, 0);
                    repeat (8) begin
                        check("no_done_after_rst", done, 0);
                        tick();
                    end
                    return;
                end
                if (gap == 2) begin
                    repeat ($urandom_range(0, 2)) begin
                        pixel_in = PIX_W'($urandom);
                        tick();
                    end
                end
                case (pat)
                    0:       p = cval;
                    1:       p = x;
                    default: p = int'($urandom_range(0, (1 << PIX_W) - 1));
                endcase
                img[y][x]   = p;
                pixel_in    = PIX_W'(p);
                pixel_valid = 1'b1;
                if (run_wr && x == 5 && y == 5) begin
                    cfg_wr_en = 1'b1;
                    cfg_addr  = 4'd4;
                    cfg_data  = COEF_W'(5);
                end
                if (x >= 2 && y >= 2) expq.push_back('{model(x, y), cyc + 4});
                lastp_cyc = cyc;
                tick();
                pixel_valid = 1'b0;
                cfg_wr_en   = 1'b0;
                if (gap == 1) begin
                    pixel_in = PIX_W'($urandom);
                    tick();
                end
            end
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (done === 1'b1) got = 1'b1;
            else tick();
        end
        check("done_seen", got, 1);
        check("done_cycle", cyc, lastp_cyc + 5);
        check("result_count", res_count, NRES);
        tick();
        check("done_pulse", done, 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_wr_en = 1'b0; cfg_addr = '0; cfg_data = '0;
        pixel_in = '0; pixel_valid = 1'b0;
        for (int i = 0; i < 9; i++) kmod[i] = K_DEF[i];
        repeat (3) tick();
        check("rst_result", result_out, 0);
        check("rst_valid", result_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        tick();

        run_frame(0, 100, 0, 0, 0, 0);              // default kernel, flat -> 0
        run_frame(1, 0, 0, 0, 0, 0);                // horizontal ramp -> -8
        for (int i = 0; i < 9; i++) cfg_write(i, 127);
        cfg_write(12, int'($urandom_range(0, 255)) - 128);   // out-of-range address
        run_frame(0, 255, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) cfg_write(i, -128);
        run_frame(0, 255, 0, 0, 0, 0);
        do_reset();
        run_frame(2, 0, 1, 0, 0, 0);                // alternating pixel_valid
        run_frame(2, 0, 2, 0, 1, 0);                // write during RUN ignored
        cfg_write(4, 5);
        run_frame(0, 1, 0, 0, 0, 0);                // -> 5
        run_frame(2, 0, 0, 0, 0, 1);                // write coincident with start
        run_frame(2, 0, 0, 1, 0, 0);                // reset at (10,10)
        run_frame(2, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) cfg_write(i, int'($urandom_range(0, 255)) - 128);
        run_frame(2, 0, 2, 0, 0, 0);

        repeat (6) tick();
        check("queue_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "timeout");
    end

endmodule
